// File: rtl/demux_1to4_16bit_reg_if.sv
// Stream bundle for the 1-to-4 demux: one valid/ready input, four valid/ready outputs.
// The producer/consumer side uses master and the demux uses slave.
interface demux_1to4_16bit_reg_if #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_WIDTH-1:0] in_sel;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [WIDTH-1:0]     out_data0;
    logic [WIDTH-1:0]     out_data1;
    logic [WIDTH-1:0]     out_data2;
    logic [WIDTH-1:0]     out_data3;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/demux_1to4_16bit_reg.sv
// Registered 1-to-4 stream demux: one-entry output register per channel so a stalled
// consumer never blocks the others, plus a wrapping transfer counter per channel.
module demux_1to4_16bit_reg #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1to4_16bit_reg_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1,
    output logic [CNT_WIDTH-1:0] cnt2,
    output logic [CNT_WIDTH-1:0] cnt3
);
    localparam int NCH = 4;

    logic [NCH-1:0]       w_valid;
    logic [NCH-1:0]       w_load;
    logic [NCH-1:0]       w_drain;
    logic [WIDTH-1:0]     w_data [NCH];
    logic [CNT_WIDTH-1:0] w_cnt  [NCH];
    logic                 w_in_ready;
    logic                 w_in_fire;

    // Ready looks only at the addressed channel; a same-cycle drain frees the slot.
    assign w_in_ready   = ~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign w_in_fire    = bus.in_valid & w_in_ready;
    assign bus.in_ready = w_in_ready;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic                 r_valid;
            logic [WIDTH-1:0]     r_data;
            logic [CNT_WIDTH-1:0] r_cnt;

            assign w_load[gi]  = w_in_fire & (bus.in_sel == SEL_WIDTH'(gi));
            assign w_drain[gi] = r_valid & bus.out_ready[gi];

            // Load wins over drain so a simultaneous drain+load keeps the slot full.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[gi]) begin
                    r_valid <= 1'b1;
                    r_data  <= bus.in_data;
                end else if (w_drain[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_drain[gi]) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_data[gi]  = r_data;
            assign w_cnt[gi]   = r_cnt;
        end
    endgenerate

    assign bus.out_valid = w_valid;
    assign bus.out_data0 = w_data[0];
    assign bus.out_data1 = w_data[1];
    assign bus.out_data2 = w_data[2];
    assign bus.out_data3 = w_data[3];

    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];
endmodule

// File: doc/demux_1to4_16bit_reg.md
Name: demux_1to4_16bit_reg

Overview:
Registered 1-to-4 stream demultiplexer. It routes a single valid/ready input stream to one of four output channels, chosen per beat by a 2-bit select. It is the distribution-side counterpart of the team's 4-to-1 16-bit data mux and sits where one producer feeds four independent consumers. Each channel has a one-entry output register, so a stalled channel never blocks traffic to the other channels. Each channel also has a wrap-around transfer counter for debug and visibility.

Parameters:
WIDTH, 16, data width of the input and of each output channel
SEL_WIDTH, 2, select width; fixed at 2 (4 channels), other values unsupported
CNT_WIDTH, 8, width of each per-channel transfer counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept the input beat this cycle
in_data  input  WIDTH  input payload
in_sel  input  SEL_WIDTH  destination channel for the beat (0..3)
out_valid  output  4  per-channel output valid; bit k belongs to channel k
out_ready  input  4  per-channel consumer ready
out_data0  output  WIDTH  channel 0 payload
out_data1  output  WIDTH  channel 1 payload
out_data2  output  WIDTH  channel 2 payload
out_data3  output  WIDTH  channel 3 payload
cnt_clr  input  1  synchronous clear of all transfer counters
cnt0..cnt3  output  CNT_WIDTH each  completed output handshakes per channel

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-safe deassert):
  - out_valid=4'b0000.
  - out_data0..3 = 0.
  - cnt0..3 = 0.
  - in_ready follows its combinational equation, so it reads 1 while every out_valid is 0.
- Handshake rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer on channel k: out_valid[k] & out_ready[k] at a rising edge.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is a combinational path from out_ready to in_ready and is intentional; there is no extra bubble.
- in_ready depends only on the selected channel. Other channels' stall state never affects it.
- Latency: an input beat accepted at edge N appears on out_data[in_sel] with out_valid[in_sel]=1 immediately after edge N (1 cycle).
- Per-channel register k, at each edge, applied in this order:
  - Load when an input transfer targets k: out_data_k <= in_data, out_valid[k] <= 1.
  - Otherwise, if an output transfer occurs on k: out_valid[k] <= 0. Data is held, not cleared.
  - Otherwise, hold.
- Simultaneous drain and load on the same channel: the register reloads, out_valid[k] stays 1, and full throughput of one beat per cycle per channel is sustained.
- Stall stability: while out_valid[k] & ~out_ready[k], out_data_k and out_valid[k] hold unchanged.
- in_sel and in_data are don't-care when in_valid=0. No channel changes state.
- At most one channel loads per cycle. Drains on multiple channels in the same cycle are independent.
- Counters:
  - cnt_k increments by 1 on every output transfer on channel k.
  - cnt_k wraps from 2^CNT_WIDTH-1 to 0.
  - cnt_clr=1 forces all counters to 0 at the edge, with priority over a same-cycle increment.
- Reset mid-operation: all buffered beats are discarded with no output handshake, and all counters are cleared.
- No state machine beyond the four valid flags. There are no latches; all outputs are fully registered except in_ready.

Test Plan:
- Reset check: rst_n=0 while out_valid=4'b0100 and cnt2=5 -> out_valid=0, out_data0..3=0 and cnt0..3=0 asynchronously; in_ready=1 after release.
- Basic routing: out_ready=4'b1111; send 0xA000,0xA001,0xA002,0xA003 with in_sel=0,1,2,3 on consecutive cycles -> each appears one cycle later on the matching out_dataK with only that out_valid bit set; cnt0..3=1.
- Independent stall:
  - Setup: out_ready[1]=0; send 0x1111 sel=1, then 0x2222 sel=1, then 0x3333 sel=3.
  - Second beat: in_ready=0 and it is held; out_data1 stays 0x1111.
  - Channel 3: still accepts 0x3333 once presented; out_data3=0x3333 next cycle.
- Back-to-back same channel: out_ready[2]=1; 8 consecutive beats 0x0100..0x0107 sel=2 -> in_ready stays 1, out_valid[2] stays 1 for 8 cycles, data in order, cnt2=8.
- Counter wrap and clear: 256 transfers on channel 0 -> cnt0 returns to 0. Assert cnt_clr on the same cycle as a channel-1 transfer -> cnt1=0, not 1.
- Mid-operation reset: channels 0 and 3 are full and stalled; pulse rst_n low for 1 cycle -> both valids clear and no output handshake is counted; the next beat with sel=3, 0xBEEF, routes correctly.
